// File: rtl/tickgen_pkg.sv
// Shared speed-code constants and the mode-state encoding for period_tick_gen.
// The mode state value doubles as the {bit1,bit0} speed code sent to the 4:1 speed mux.
package tickgen_pkg;

    localparam logic [1:0] SEL_2S  = 2'b00;
    localparam logic [1:0] SEL_4S  = 2'b01;
    localparam logic [1:0] SEL_8S  = 2'b10;
    localparam logic [1:0] SEL_OFF = 2'b11;

    typedef enum logic [1:0] {
        S2 = SEL_2S,
        S4 = SEL_4S,
        S8 = SEL_8S,
        S0 = SEL_OFF
    } mode_e;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchronizer, stability counter and press (rising-edge) pulse.
// The raw-edge-to-press latency is DEBOUNCE_CYC+2 cycles, so the consumer acts one edge later.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;
    logic          deb_dly_q;
    logic          press_q, press_d;

    // The counter restarts whenever the synced input agrees with the accepted state,
    // so only an unbroken run of disagreement can flip it.
    always_comb begin
        cnt_d   = '0;
        deb_d   = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 2)) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        press_d = deb_q & ~deb_dly_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            press_q   <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/period_tick_gen.sv
// Square-wave source (2/4/8 s) plus speed-code mode FSM and on/off toggle for the toy's speed mux.
// Optional TICKGEN_SYNC_RESTART_EN: mode presses and power-on restart the waves low, phase-aligned.
module period_tick_gen
    import tickgen_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_mode,
    input  logic btn_power,
    output logic clk2s,
    output logic clk4s,
    output logic clk8s,
    output logic bit0,
    output logic bit1,
    output logic on_off
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    sec_q, sec_d;
    mode_e         mode_q, mode_d;
    logic          on_off_q, on_off_d;
    logic          tick1s;
    logic          restart;
    logic          mode_press, power_press;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_mode),
        .press (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_power_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_power),
        .press (power_press)
    );

    always_comb begin
`ifdef TICKGEN_SYNC_RESTART_EN
        restart = mode_press | (power_press & ~on_off_q);
`else
        restart = 1'b0;
`endif
    end

    // Restart wins over the 1 s tick so every wave comes back low on the user's edge.
    always_comb begin
        tick1s  = (presc_q == PW'(CLK_HZ - 1));
        presc_d = tick1s ? '0 : presc_q + PW'(1);
        sec_d   = tick1s ? sec_q + 3'd1 : sec_q;
        if (restart) begin
            presc_d = '0;
            sec_d   = '0;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_press) begin
            case (mode_q)
                S2:      mode_d = S4;
                S4:      mode_d = S8;
                S8:      mode_d = S0;
                S0:      mode_d = S2;
                default: mode_d = S2;
            endcase
        end
        on_off_d = on_off_q ^ power_press;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            sec_q    <= '0;
            mode_q   <= S2;
            on_off_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            sec_q    <= sec_d;
            mode_q   <= mode_d;
            on_off_q <= on_off_d;
        end
    end

    assign clk2s  = sec_q[0];
    assign clk4s  = sec_q[1];
    assign clk8s  = sec_q[2];
    assign bit0   = mode_q[0];
    assign bit1   = mode_q[1];
    assign on_off = on_off_q;

endmodule
